// File: rtl/imu_pkg.sv
// Shared types and command constants for the IMU polling sequencer.
// IMU_ROLL_EN selects whether roll-rate registers are read alongside pitch.
package imu_pkg;

  typedef enum logic [2:0] {
    INIT,
    CFG,
    CFG_WT,
    IDLE,
    RD,
    RD_WT,
    VLD
  } imu_state_t;

  localparam int CFG_CNT = 4;
  localparam logic [1:0] CFG_LAST = 2'(CFG_CNT - 1);

`ifdef IMU_ROLL_EN
  localparam int RD_CNT = 4;
`else
  localparam int RD_CNT = 2;
`endif
  localparam logic [1:0] RD_LAST = 2'(RD_CNT - 1);

  // Configuration writes: INT enable, accel, gyro, rounding.
  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    logic [15:0] c;
    case (idx)
      2'd0:    c = 16'h0D02;
      2'd1:    c = 16'h1053;
      2'd2:    c = 16'h1150;
      default: c = 16'h1460;
    endcase
    return c;
  endfunction

  // Read commands: pitch L/H, then roll L/H.
  function automatic logic [15:0] rd_cmd(input logic [1:0] ridx);
    logic [15:0] c;
    case (ridx)
      2'd0:    c = 16'hA200;
      2'd1:    c = 16'hA300;
      2'd2:    c = 16'hA400;
      default: c = 16'hA500;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imu_poll_ctrl.sv
// IMU command sequencer: power-up wait, config writes, interrupt-driven rate reads.
// Optional feature macro: IMU_ROLL_EN (adds roll-rate reads and the roll_rt port).
module imu_poll_ctrl
  import imu_pkg::*;
#(
  parameter int INIT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
`ifdef IMU_ROLL_EN
  output logic [15:0] roll_rt,
`endif
  output logic        vld
);

  imu_state_t  state_reg, state_next;
  logic [INIT_W-1:0] timer_reg, timer_next;
  logic [1:0]  idx_reg, idx_next;
  logic [1:0]  ridx_reg, ridx_next;
  logic        wrt_reg, wrt_next;
  logic [15:0] cmd_reg, cmd_next;
  logic [15:0] ptch_reg, ptch_next;
  logic        vld_reg, vld_next;
`ifdef IMU_ROLL_EN
  logic [15:0] roll_reg, roll_next;
`endif

  logic int_meta_reg, int_sync_reg, int_prev_reg;
  logic int_rise;
  logic unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  // INT is asynchronous: two flops to settle, a third to find the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta_reg <= 1'b0;
      int_sync_reg <= 1'b0;
      int_prev_reg <= 1'b0;
    end else begin
      int_meta_reg <= INT;
      int_sync_reg <= int_meta_reg;
      int_prev_reg <= int_sync_reg;
    end
  end

  assign int_rise = int_sync_reg & ~int_prev_reg;

  // One byte register per read-table entry; byte_now folds in the byte being
  // captured this cycle so the output update can happen on the same edge.
  logic [RD_CNT-1:0][7:0] byte_now;

  generate
    for (genvar gi = 0; gi < RD_CNT; gi++) begin : g_byte
      logic [7:0] byte_reg;
      logic       cap;

      assign cap = (state_reg == RD_WT) && done && (ridx_reg == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg <= 8'h00;
        end else if (cap) begin
          byte_reg <= rd_data[7:0];
        end
      end

      assign byte_now[gi] = cap ? rd_data[7:0] : byte_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      timer_reg <= '0;
      idx_reg   <= 2'd0;
      ridx_reg  <= 2'd0;
      wrt_reg   <= 1'b0;
      cmd_reg   <= 16'h0000;
      ptch_reg  <= 16'h0000;
      vld_reg   <= 1'b0;
`ifdef IMU_ROLL_EN
      roll_reg  <= 16'h0000;
`endif
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
      ridx_reg  <= ridx_next;
      wrt_reg   <= wrt_next;
      cmd_reg   <= cmd_next;
      ptch_reg  <= ptch_next;
      vld_reg   <= vld_next;
`ifdef IMU_ROLL_EN
      roll_reg  <= roll_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    ridx_next  = ridx_reg;
    wrt_next   = 1'b0;
    cmd_next   = cmd_reg;
    ptch_next  = ptch_reg;
    vld_next   = 1'b0;
`ifdef IMU_ROLL_EN
    roll_next  = roll_reg;
`endif

    unique case (state_reg)
      INIT: begin
        if (timer_reg == {INIT_W{1'b1}}) begin
          state_next = CFG;
          idx_next   = 2'd0;
        end else begin
          timer_next = timer_reg + INIT_W'(1);
        end
      end
      CFG: state_next = CFG_WT;
      CFG_WT: begin
        if (done) begin
          if (idx_reg == CFG_LAST) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = CFG;
          end
        end
      end
      IDLE: begin
        if (int_rise) begin
          ridx_next  = 2'd0;
          state_next = RD;
        end
      end
      RD: state_next = RD_WT;
      RD_WT: begin
        if (done) begin
          if (ridx_reg == RD_LAST) begin
            state_next = VLD;
            ptch_next  = {byte_now[1], byte_now[0]};
`ifdef IMU_ROLL_EN
            roll_next  = {byte_now[3], byte_now[2]};
`endif
            vld_next   = 1'b1;
          end else begin
            ridx_next  = ridx_reg + 2'd1;
            state_next = RD;
          end
        end
      end
      VLD: state_next = IDLE;
      default: state_next = INIT;
    endcase

    // wrt and cmd are registered, so they are loaded on entry to the issuing state.
    if (state_next == CFG) begin
      wrt_next = 1'b1;
      cmd_next = cfg_cmd(idx_next);
    end else if (state_next == RD) begin
      wrt_next = 1'b1;
      cmd_next = rd_cmd(ridx_next);
    end
  end

  assign wrt     = wrt_reg;
  assign cmd     = cmd_reg;
  assign ptch_rt = ptch_reg;
  assign vld     = vld_reg;
`ifdef IMU_ROLL_EN
  assign roll_rt = roll_reg;
`endif

endmodule

// File: tb/tb_imu_poll_ctrl.sv
// Self-checking bench for imu_poll_ctrl: behavioural SPI slave, table vectors,
// randomized reads and hand-written corner sequences.
`timescale 1ns/1ps
module tb_imu_poll_ctrl;

  localparam int INIT_W = 4;
`ifdef IMU_ROLL_EN
  localparam int NRD = 4;
`else
  localparam int NRD = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b1;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic        vld;
`ifdef IMU_ROLL_EN
  logic [15:0] roll_rt;
`endif

  imu_poll_ctrl #(.INIT_W(INIT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .ptch_rt (ptch_rt),
`ifdef IMU_ROLL_EN
    .roll_rt (roll_rt),
`endif
    .vld     (vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // SPI slave model plus transaction monitor, evaluated away from the active edge.
  logic [7:0]  resp_q[$];
  logic [15:0] cmd_log[$];
  int          lat = 40;
  int          busy_cnt = 0;
  bit          pending_rd = 1'b0;
  bit          wrt_prev = 1'b0;
  int          b2b_cnt = 0;
  int          vld_cnt = 0;
  logic [15:0] vld_ptch = 16'h0000;
  logic [15:0] vld_roll = 16'h0000;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      done     = 1'b1;
      wrt_prev = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          done = 1'b1;
          if (pending_rd) begin
            rd_data[15:8] = 8'($urandom);
            rd_data[7:0]  = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
          end else begin
            rd_data = 16'($urandom);
          end
        end
      end
      if (wrt) begin
        done       = 1'b0;
        busy_cnt   = lat;
        pending_rd = cmd[15];
        cmd_log.push_back(cmd);
        if (wrt_prev) b2b_cnt++;
        $display("[%0t] spi %s cmd=0x%04h", $time, cmd[15] ? "read " : "write", cmd);
      end
      wrt_prev = wrt;
      if (vld) begin
        vld_cnt++;
        vld_ptch = ptch_rt;
`ifdef IMU_ROLL_EN
        vld_roll = roll_rt;
`endif
        $display("[%0t] sample vld ptch_rt=0x%04h roll=0x%04h", $time, ptch_rt, vld_roll);
      end
    end
  end

  task automatic pulse_int();
    @(negedge clk);
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic wait_cmds(input int n_cmds, input int budget, input string tag);
    int n = 0;
    while (cmd_log.size() < n_cmds && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_timeout"}, (cmd_log.size() >= n_cmds), 1);
  endtask

  task automatic check_cfg_seq(input string tag);
    logic [15:0] exp_cfg [4];
    exp_cfg = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_cfg%0d", tag, i),
            (i < cmd_log.size()) ? 32'(cmd_log[i]) : 32'hDEAD0000, 32'(exp_cfg[i]));
  endtask

  // One interrupt-driven read; expected values come from the caller.
  task automatic do_read(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [15:0] exp_p, input logic [15:0] exp_r);
    logic [7:0]  bq [4];
    logic [15:0] exp_cmd;
    int start;
    int n;
    bq = '{b0, b1, b2, b3};
    resp_q.delete();
    for (int i = 0; i < NRD; i++) resp_q.push_back(bq[i]);
    cmd_log.delete();
    start = vld_cnt;
    pulse_int();
    n = 0;
    while (vld_cnt == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld_seen"}, (vld_cnt != start), 1);
    repeat (20) @(negedge clk);
    check({tag, "_vld_once"}, vld_cnt - start, 1);
    check({tag, "_nreads"}, cmd_log.size(), NRD);
    for (int i = 0; i < NRD; i++) begin
      exp_cmd = 16'hA200 + 16'(i * 256);
      check($sformatf("%s_rdcmd%0d", tag, i),
            (i < cmd_log.size()) ? 32'(cmd_log[i]) : 32'hDEAD0000, 32'(exp_cmd));
    end
    check({tag, "_ptch"}, vld_ptch, exp_p);
    check({tag, "_ptch_hold"}, ptch_rt, exp_p);
`ifdef IMU_ROLL_EN
    check({tag, "_roll"}, vld_roll, exp_r);
`else
    if (exp_r === 16'hxxxx) $display("note: roll expectation unused");
`endif
  endtask

  typedef struct packed {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] exp_p, exp_r;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    int n;
    logic [7:0] r0, r1, r2, r3;

    vecs[0] = '{8'hCD, 8'hAB, 8'h11, 8'h22, 16'hABCD, 16'h2211};
    vecs[1] = '{8'h18, 8'hFC, 8'h00, 8'h80, 16'hFC18, 16'h8000};
    vecs[2] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{8'hFF, 8'h7F, 8'h01, 8'h00, 16'h7FFF, 16'h0001};
    vecs[4] = '{8'h00, 8'h80, 8'h34, 8'h12, 16'h8000, 16'h1234};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wrt", wrt, 0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_ptch", ptch_rt, 16'h0000);
    check("rst_vld", vld, 0);

    // Power-up wait then configuration
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("init_no_wrt", cmd_log.size(), 0);
    wait_cmds(1, 50, "first_wrt");
    check("first_cmd", (cmd_log.size() > 0) ? 32'(cmd_log[0]) : 32'hDEAD0000, 32'h0D02);
    wait_cmds(4, 1000, "cfg");
    check_cfg_seq("boot");
    repeat (150) @(negedge clk);
    check("idle_after_cfg", cmd_log.size(), 4);

    // Table-driven reads
    for (int v = 0; v < 5; v++)
      do_read($sformatf("vec%0d", v), vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3,
              vecs[v].exp_p, vecs[v].exp_r);

    // Randomized reads against the {high,low} reference
    for (int k = 0; k < 20; k++) begin
      lat = $urandom_range(8, 1);
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      do_read($sformatf("rnd%0d", k), r0, r1, r2, r3, {r1, r0}, {r3, r2});
      repeat ($urandom_range(10, 0)) @(negedge clk);
    end
    lat = 40;

    // INT edge during RD_WT is dropped, not queued
    resp_q.delete();
    for (int i = 0; i < NRD; i++) resp_q.push_back(8'h5A);
    cmd_log.delete();
    start = vld_cnt;
    pulse_int();
    wait_cmds(1, 100, "intmid");
    repeat (5) @(negedge clk);
    pulse_int();
    n = 0;
    while (vld_cnt == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (300) @(negedge clk);
    check("intmid_vld_once", vld_cnt - start, 1);
    check("intmid_nreads", cmd_log.size(), NRD);
    do_read("after_intmid", 8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678);

    // Reset in the middle of a read
    resp_q.delete();
    for (int i = 0; i < NRD; i++) resp_q.push_back(8'hC3);
    cmd_log.delete();
    pulse_int();
    wait_cmds(1, 100, "rstmid");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_wrt", wrt, 0);
    check("rstmid_cmd", cmd, 16'h0000);
    check("rstmid_ptch", ptch_rt, 16'h0000);
    check("rstmid_vld", vld, 0);
    repeat (3) @(negedge clk);
    cmd_log.delete();
    rst_n = 1'b1;
    wait_cmds(4, 1000, "rerun");
    check_cfg_seq("rerun");
    repeat (150) @(negedge clk);
    do_read("post_rst", 8'h18, 8'hFC, 8'h9A, 8'hBC, 16'hFC18, 16'hBC9A);

    check("no_b2b_wrt", b2b_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
